decrypt: RTL and testbench
==========================

Name: decrypt

Overview:
- Streaming LWE-style decryption accumulator.
- Each clock accepts one (secret-key entry, ciphertext entry) pair tagged with a row index.
- Row 0 opens a new decryption and clears the running sum. Every nonzero row accumulates sk*ct modulo CIPHERTEXT_MODULUS.
- The plaintext output is the accumulator reduced modulo PLAINTEXT_MODULUS. Sits downstream of key/ciphertext storage that sequences rows 0..DIMENSION.

Parameters:
- PLAINTEXT_MODULUS, 64, plaintext modulus p; power of two.
- PLAINTEXT_WIDTH, 6, bits of result; log2(p).
- CIPHERTEXT_MODULUS, 1024, ciphertext modulus q; power of two, q >= p.
- CIPHERTEXT_WIDTH, 21, width of key and ciphertext entries.
- DIMENSION, 1, LWE dimension; rows run 0..DIMENSION.
- BIG_N, 30, internal product width in bits; must be >= 2*log2(q)+2. The product is formed at this width before reduction.

Ports:
- clk  input  1  clock, rising edge active.
- rst_n  input  1  asynchronous active-low reset.
- secretkey_entry  input  CIPHERTEXT_WIDTH  secret-key entry, unsigned.
- ciphertext_entry  input  CIPHERTEXT_WIDTH  ciphertext entry, signed two's complement.
- row  input  DIMENSION+1  row index of the current pair.
- result  output  PLAINTEXT_WIDTH  decrypted plaintext.

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset (rst_n=0), effective immediately and independent of clk:
  - acc <= 0, result = 0.
  - Held while rst_n is low; reset mid-sequence discards the partial sum.
- State: acc, CIPHERTEXT_WIDTH bits, invariant 0 <= acc < q.
- Every rising clk with rst_n=1:
  - prod = unsigned(secretkey_entry) * signed(ciphertext_entry), computed signed at BIG_N bits.
  - row == 0: acc <= 0. The row-0 pair is not accumulated; it marks the start of a decryption.
  - row != 0: acc <= (acc + prod) mod q, always reduced into [0, q). Negative sums wrap up: add q multiples, or take the low log2(q) bits, since q is a power of two.
- Row values above DIMENSION are treated like any nonzero row (accumulate); no error flag.
- result = acc mod p (low PLAINTEXT_WIDTH bits of acc). Driven from registered acc only, with no combinational path from the data inputs.
- Latency: result reflects all pairs sampled up to and including the most recent rising edge. Valid one edge after row DIMENSION is presented.
- No handshake: a pair is consumed on every edge. The upstream block holds row at 0 between decryptions to keep acc cleared.
- Back-to-back decryptions: presenting row 0 immediately after row DIMENSION is legal. result holds the previous plaintext until that row-0 edge, then reads 0.
- Accumulation without an intervening row 0 continues the running sum modulo q.

Test Plan:
- Reset: rst_n=0 mid-accumulation -> result=0 without a clock edge; stays 0 until a nonzero row is sampled after release.
- Nominal (defaults): row0 sk=1 ct=895, row1 sk=173 ct=894, one edge each -> result=38 (154662 mod 1024 = 38, mod 64 = 38).
- Small values: row0 sk=1 ct=7, row1 sk=2 ct=40 -> acc=80, result=16.
- Negative ciphertext: row0 (any), row1 sk=3 ct=-5 -> acc=1009, result=49.
- Continued accumulation: row0, then row1 sk=173 ct=894 on two consecutive edges -> acc=76, result=12. A following row0 edge -> result=0.
- Back-to-back: nominal sequence -> result=38; next edge row0 -> result=0; next edge row1 sk=2 ct=40 -> result=16.

Source files
------------

// File: rtl/decrypt.sv
// decrypt: streaming LWE decryption accumulator. Row 0 clears the running sum,
// every other row adds sk*ct mod q; result is the sum reduced mod p.
// Revision: 1.0
`default_nettype none

module decrypt #(
    parameter int PLAINTEXT_MODULUS  = 64,
    parameter int PLAINTEXT_WIDTH    = 6,
    parameter int CIPHERTEXT_MODULUS = 1024,
    parameter int CIPHERTEXT_WIDTH   = 21,
    parameter int DIMENSION          = 1,
    parameter int BIG_N              = 30
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [CIPHERTEXT_WIDTH-1:0] secretkey_entry,
    input  logic [CIPHERTEXT_WIDTH-1:0] ciphertext_entry,
    input  logic [DIMENSION:0]          row,
    output logic [PLAINTEXT_WIDTH-1:0]  result
);

    localparam int EXT_W = BIG_N - CIPHERTEXT_WIDTH;
    localparam logic [BIG_N-1:0] Q_MASK = BIG_N'(CIPHERTEXT_MODULUS - 1);

    logic [CIPHERTEXT_WIDTH-1:0] acc;
    logic signed [BIG_N-1:0]     sk_ext;
    logic signed [BIG_N-1:0]     ct_ext;
    logic [BIG_N-1:0]            prod;
    logic [BIG_N-1:0]            acc_ext;
    logic [BIG_N-1:0]            sum_mod;

    // Key is unsigned (zero-extend), ciphertext is two's complement (sign-extend).
    // Truncating the product to BIG_N bits is harmless: q divides 2^BIG_N.
    always_comb begin
        sk_ext  = $signed({{EXT_W{1'b0}}, secretkey_entry});
        ct_ext  = $signed({{EXT_W{ciphertext_entry[CIPHERTEXT_WIDTH-1]}}, ciphertext_entry});
        prod    = $unsigned(sk_ext * ct_ext);
        acc_ext = {{EXT_W{1'b0}}, acc};
        sum_mod = (acc_ext + prod) & Q_MASK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (row == '0) begin
            acc <= '0;
        end else begin
            acc <= CIPHERTEXT_WIDTH'(sum_mod);
        end
    end

    assign result = acc[PLAINTEXT_WIDTH-1:0];

endmodule

`default_nettype wire

// File: tb/tb_decrypt.sv
// tb_decrypt: directed table of decryption sequences, reset corner cases and
// randomized pairs checked against an arithmetic reference model.
`default_nettype none

module tb_decrypt;

    localparam int P  = 64;
    localparam int Q  = 1024;
    localparam int CW = 21;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] sk = '0;
    logic [CW-1:0] ct = '0;
    logic [1:0]    row = '0;
    logic [PW-1:0] result;

    int n_vec = 0;
    int n_err = 0;

    decrypt #(
        .PLAINTEXT_MODULUS (P),
        .PLAINTEXT_WIDTH   (PW),
        .CIPHERTEXT_MODULUS(Q),
        .CIPHERTEXT_WIDTH  (CW),
        .DIMENSION         (1),
        .BIG_N             (30)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .secretkey_entry (sk),
        .ciphertext_entry(ct),
        .row             (row),
        .result          (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] sk;
        logic [CW-1:0] ct;
        logic [1:0]    row;
        logic [PW-1:0] exp;
    } vec_t;

    vec_t tbl[20];

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: result=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step(input logic [CW-1:0] s, input logic [CW-1:0] c, input logic [1:0] r);
        sk  = s;
        ct  = c;
        row = r;
        @(posedge clk);
        #1;
    endtask

    // Reference: signed product of unsigned key and signed ciphertext, reduced mod q.
    function automatic longint model_next(input longint acc_m, input logic [CW-1:0] s,
                                          input logic [CW-1:0] c, input logic [1:0] r);
        longint prod, sum;
        if (r == 2'd0) return 0;
        prod = longint'(s) * (longint'(c) - (c[CW-1] ? (longint'(1) << CW) : 0));
        sum  = (acc_m + prod) % Q;
        if (sum < 0) sum += Q;
        return sum;
    endfunction

    initial begin
        longint acc_m;
        // nominal
        tbl[0]  = '{21'd1,   21'd895,     2'd0, 6'd0};
        tbl[1]  = '{21'd173, 21'd894,     2'd1, 6'd38};
        // small values
        tbl[2]  = '{21'd1,   21'd7,       2'd0, 6'd0};
        tbl[3]  = '{21'd2,   21'd40,      2'd1, 6'd16};
        // negative ciphertext
        tbl[4]  = '{21'd9,   21'd9,       2'd0, 6'd0};
        tbl[5]  = '{21'd3,   21'h1FFFFB,  2'd1, 6'd49};
        // continued accumulation then row 0
        tbl[6]  = '{21'd1,   21'd0,       2'd0, 6'd0};
        tbl[7]  = '{21'd173, 21'd894,     2'd1, 6'd38};
        tbl[8]  = '{21'd173, 21'd894,     2'd1, 6'd12};
        tbl[9]  = '{21'd0,   21'd0,       2'd0, 6'd0};
        // back-to-back
        tbl[10] = '{21'd1,   21'd895,     2'd0, 6'd0};
        tbl[11] = '{21'd173, 21'd894,     2'd1, 6'd38};
        tbl[12] = '{21'd0,   21'd0,       2'd0, 6'd0};
        tbl[13] = '{21'd2,   21'd40,      2'd1, 6'd16};
        // row above DIMENSION accumulates
        tbl[14] = '{21'd0,   21'd0,       2'd0, 6'd0};
        tbl[15] = '{21'd2,   21'd40,      2'd3, 6'd16};
        tbl[16] = '{21'd1,   21'd5,       2'd2, 6'd21};
        // large magnitudes: key 2^20, ct -1 -> -2^20 mod 1024 = 0
        tbl[17] = '{21'd0,   21'd0,       2'd0, 6'd0};
        tbl[18] = '{21'h100000, 21'h1FFFFF, 2'd1, 6'd0};
        tbl[19] = '{21'h1FFFFF, 21'd1,    2'd1, 6'd63};

        #1;
        check("reset_initial", result, 6'd0);
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].sk, tbl[i].ct, tbl[i].row);
            check($sformatf("table[%0d]", i), result, tbl[i].exp);
        end

        // asynchronous reset mid-accumulation
        step(21'd1, 21'd0, 2'd0);
        step(21'd2, 21'd40, 2'd1);
        check("pre_reset", result, 6'd16);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", result, 6'd0);
        step(21'd2, 21'd40, 2'd1);
        check("reset_held", result, 6'd0);
        #2;
        rst_n = 1'b1;
        step(21'd0, 21'd0, 2'd0);
        check("after_release_row0", result, 6'd0);
        step(21'd2, 21'd40, 2'd1);
        check("after_release_row1", result, 6'd16);

        // randomized pairs against the reference model
        step(21'd0, 21'd0, 2'd0);
        acc_m = 0;
        for (int i = 0; i < 300; i++) begin
            logic [CW-1:0] rs, rc;
            logic [1:0]    rr;
            rs = CW'($urandom);
            rc = CW'($urandom);
            rr = ($urandom_range(0, 3) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            acc_m = model_next(acc_m, rs, rc, rr);
            step(rs, rc, rr);
            check($sformatf("random[%0d]", i), result, PW'(acc_m % P));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
